// File: rtl/pdm_player.sv
// pdm_player: streams packed 7-bit samples from word RAM as a first-order PDM bitstream,
// with a one-word prefetch buffer and sticky underrun reporting.
module pdm_player #(
    parameter int SAMPLE_W = 8,
    parameter int CLOCKS   = 240,
    parameter int ADDR_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  play_en,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     num_words,
    output logic                  ram_rd,
    output logic [ADDR_W-1:0]     ram_addr,
    input  logic [4*SAMPLE_W-1:0] ram_rdata,
    input  logic                  ram_rvalid,
    output logic                  pdm_out,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);
    localparam int CW = $clog2(CLOCKS);
    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;
    state_t state;
    logic [ADDR_W-1:0] next_addr, fetched, total, words_left;
    logic [4*SAMPLE_W-1:0] play_word, buf_word, shifted;
    logic buf_full, pending;
    logic [1:0] idx;
    logic [CW-1:0] cnt;
    logic [7:0] acc, sum;
    logic [6:0] value;
    logic period_end, can_fetch;
    // index 0 is the most significant sample; its MSB is ignored
    assign shifted    = play_word << (idx * SAMPLE_W);
    assign value      = shifted[4*SAMPLE_W-2 -: 7];
    assign sum        = acc + {1'b0, value};
    assign period_end = cnt == CW'(CLOCKS - 1);
    assign can_fetch  = !buf_full && !pending && fetched != total;
    assign busy       = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pdm_out    <= 1'b0;
            ram_rd     <= 1'b0;
            ram_addr   <= '0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            idx        <= '0;
            buf_full   <= 1'b0;
            buf_word   <= '0;
            play_word  <= '0;
            pending    <= 1'b0;
            next_addr  <= '0;
            fetched    <= '0;
            total      <= '0;
            words_left <= '0;
        end else begin
            ram_rd <= 1'b0;
            done   <= 1'b0;
            if (state == IDLE) begin
                if (play_en && num_words != '0) begin
                    state      <= FETCH;
                    ram_rd     <= 1'b1;
                    ram_addr   <= base_addr;
                    next_addr  <= base_addr + 1'b1;
                    fetched    <= ADDR_W'(1);
                    total      <= num_words;
                    words_left <= num_words;
                    pending    <= 1'b1;
                    underrun   <= 1'b0;
                    acc        <= '0;
                    buf_full   <= 1'b0;
                end
            end else if (!play_en) begin
                state    <= IDLE;
                pdm_out  <= 1'b0;
                pending  <= 1'b0;
                buf_full <= 1'b0;
            end else if (state == FETCH) begin
                if (ram_rvalid && pending) begin
                    play_word <= ram_rdata;
                    idx       <= '0;
                    cnt       <= '0;
                    pending   <= 1'b0;
                    state     <= PLAY;
                end
            end else begin
                pdm_out <= sum >= 8'd127;
                acc     <= sum >= 8'd127 ? sum - 8'd127 : sum;
                cnt     <= period_end ? '0 : cnt + 1'b1;
                if (period_end && idx != 2'd3)
                    idx <= idx + 1'b1;
                // underrun keeps idx at 3, so the last sample repeats until data lands
                if (period_end && idx == 2'd3) begin
                    if (words_left == ADDR_W'(1)) begin
                        done    <= 1'b1;
                        state   <= IDLE;
                        pdm_out <= 1'b0;
                    end else if (buf_full) begin
                        play_word  <= buf_word;
                        idx        <= '0;
                        buf_full   <= 1'b0;
                        words_left <= words_left - 1'b1;
                    end else begin
                        underrun <= 1'b1;
                    end
                end
                if (can_fetch) begin
                    ram_rd    <= 1'b1;
                    ram_addr  <= next_addr;
                    next_addr <= next_addr + 1'b1;
                    fetched   <= fetched + 1'b1;
                    pending   <= 1'b1;
                end
                if (ram_rvalid && pending) begin
                    buf_word <= ram_rdata;
                    buf_full <= 1'b1;
                    pending  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pdm_player.sv
// tb_pdm_player: directed and randomized playback checked against an arithmetic PDM model
// and a latency-programmable RAM responder.
module tb_pdm_player;
    logic clk = 1'b0, rst = 1'b1, play_en = 1'b0, ram_rvalid = 1'b0;
    logic [15:0] base_addr = '0, num_words = '0;
    logic [31:0] ram_rdata = '0;
    logic ram_rd, pdm_out, busy, done, underrun;
    logic [15:0] ram_addr;
    int checks = 0, failures = 0;
    logic [31:0] mem [logic [15:0]];
    int lats[$];
    int def_lat = 1;
    bit pend = 0;
    int due = 0, cyc = 0, done_cnt = 0;
    logic [15:0] paddr = '0;
    logic pdm_q[$], und_q[$];
    logic [15:0] rd_addrs[$];
    bit exp_q[$];

    always #5 clk = ~clk;

    pdm_player dut (
        .clk(clk), .rst(rst), .play_en(play_en), .base_addr(base_addr), .num_words(num_words),
        .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid),
        .pdm_out(pdm_out), .busy(busy), .done(done), .underrun(underrun)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: sample outputs, then act as the RAM for the next edge
    task automatic tick();
        bit was;
        @(negedge clk);
        cyc++;
        was = pend;
        pdm_q.push_back(pdm_out);
        und_q.push_back(underrun);
        if (done) done_cnt++;
        ram_rvalid = 1'b0;
        if (pend && cyc >= due) begin
            ram_rvalid = 1'b1;
            ram_rdata = mem.exists(paddr) ? mem[paddr] : 32'h0;
            pend = 0;
        end
        if (ram_rd) begin
            chk("one_outstanding", 64'(was), 64'd0);
            rd_addrs.push_back(ram_addr);
            pend = 1;
            paddr = ram_addr;
            due = cyc + (lats.size() > 0 ? lats.pop_front() : def_lat);
        end
    endtask

    task automatic build_model(input logic [15:0] base, input int n);
        int acc;
        int v;
        logic [15:0] a;
        acc = 0;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            a = base + 16'(k);
            for (int s = 0; s < 4; s++) begin
                v = int'((mem[a] >> (24 - 8 * s)) & 32'h7F);
                for (int c = 0; c < 240; c++) begin
                    acc += v;
                    exp_q.push_back(acc >= 127);
                    if (acc >= 127) acc -= 127;
                end
            end
        end
        exp_q[exp_q.size() - 1] = 1'b0;
    endtask

    task automatic run(input logic [15:0] base, input logic [15:0] n, input int budget,
                       input bit hold, output int off);
        rd_addrs.delete(); pdm_q.delete(); und_q.delete();
        done_cnt = 0;
        base_addr = base; num_words = n; play_en = 1'b1; off = -1;
        for (int i = 0; i < budget && off < 0; i++) begin
            tick();
            if (done) begin
                off = i;
                if (!hold) play_en = 1'b0;
            end
        end
        chk("done_seen", 64'(off >= 0), 64'd1);
    endtask

    task automatic check_stream(input string tag, input int lat);
        int bad;
        bit e;
        bad = 0;
        for (int i = 0; i < pdm_q.size(); i++) begin
            e = (i >= lat + 2 && i - lat - 2 < exp_q.size()) ? exp_q[i - lat - 2] : 1'b0;
            if (pdm_q[i] !== logic'(e)) bad++;
        end
        chk(tag, 64'(bad), 64'd0);
    endtask

    function automatic int ones(input int lo, input int hi);
        int c;
        c = 0;
        for (int i = lo; i <= hi && i < pdm_q.size(); i++) if (pdm_q[i] === 1'b1) c++;
        return c;
    endfunction

    initial begin
        int off, lat, n, p1;
        logic [15:0] base;
        repeat (3) tick();
        chk("reset_outs", 64'({pdm_out, ram_rd, busy, done, underrun}), 64'd0);
        chk("reset_addr", 64'(ram_addr), 64'd0);
        rst = 1'b0;
        tick();

        mem[16'h0100] = 32'h7F40_0000;
        lats = '{2};
        run(16'h0100, 16'd1, 3000, 1'b1, off);
        chk("one_word_done_off", 64'(off), 64'(2 + 1 + 960));
        chk("one_word_rd_cnt", 64'(rd_addrs.size()), 64'd1);
        build_model(16'h0100, 1);
        check_stream("one_word_stream", 2);
        chk("p0_ones", 64'(ones(4, 243)), 64'd240);
        p1 = ones(244, 483);
        chk("p1_ones", 64'(p1 == 120 || p1 == 121), 64'd1);
        chk("tail_zeros", 64'(ones(484, 963)), 64'd0);
        tick();
        chk("restart_rd", 64'(ram_rd), 64'd1);
        play_en = 1'b0;
        repeat (10) tick();
        chk("restart_abort_busy", 64'(busy), 64'd0);

        def_lat = 1;
        for (int k = 0; k < 3; k++) mem[16'h0010 + 16'(k)] = $urandom;
        run(16'h0010, 16'd3, 5000, 1'b0, off);
        chk("gapless_done_off", 64'(off), 64'(1 + 1 + 2880));
        chk("gapless_rd_cnt", 64'(rd_addrs.size()), 64'd3);
        for (int k = 0; k < 3; k++) chk("gapless_addr", 64'(rd_addrs[k]), 64'(16'h0010 + 16'(k)));
        chk("gapless_underrun", 64'(underrun), 64'd0);
        build_model(16'h0010, 3);
        check_stream("gapless_stream", 1);
        repeat (3) tick();
        chk("done_once", 64'(done_cnt), 64'd1);

        mem[16'h0200] = $urandom; mem[16'h0201] = $urandom;
        lats = '{1, 1000};
        run(16'h0200, 16'd2, 5000, 1'b0, off);
        chk("underrun_done_off", 64'(off), 64'(1 + 1 + 1920 + 240));
        chk("underrun_before", 64'(und_q[961]), 64'd0);
        chk("underrun_after", 64'(und_q[962]), 64'd1);
        repeat (3) tick();
        chk("underrun_sticky", 64'(underrun), 64'd1);
        chk("underrun_done_once", 64'(done_cnt), 64'd1);

        mem[16'hFFFF] = $urandom; mem[16'h0000] = $urandom;
        run(16'hFFFF, 16'd2, 5000, 1'b0, off);
        chk("wrap_addr0", 64'(rd_addrs[0]), 64'h0FFFF);
        chk("wrap_addr1", 64'(rd_addrs[1]), 64'h00000);
        build_model(16'hFFFF, 2);
        check_stream("wrap_stream", 1);
        tick();

        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(1, 3);
            lat = $urandom_range(1, 6);
            base = 16'($urandom);
            def_lat = lat;
            for (int k = 0; k < n; k++) mem[base + 16'(k)] = $urandom;
            run(base, 16'(n), 5000, 1'b0, off);
            chk("rand_done_off", 64'(off), 64'(lat + 1 + 960 * n));
            chk("rand_rd_cnt", 64'(rd_addrs.size()), 64'(n));
            chk("rand_underrun", 64'(underrun), 64'd0);
            build_model(base, n);
            check_stream("rand_stream", lat);
            tick();
        end
        def_lat = 1;

        mem[16'h0300] = 32'h7F7F_7F7F; mem[16'h0301] = $urandom;
        lats = '{1, 150};
        rd_addrs.delete(); pdm_q.delete(); done_cnt = 0;
        base_addr = 16'h0300; num_words = 16'd2; play_en = 1'b1;
        repeat (102) tick();
        chk("abort_pre_busy", 64'(busy), 64'd1);
        play_en = 1'b0;
        tick();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_pdm", 64'(pdm_out), 64'd0);
        pdm_q.delete();
        repeat (200) tick();
        chk("abort_idle_ones", 64'(ones(0, 199)), 64'd0);
        chk("abort_rd_cnt", 64'(rd_addrs.size()), 64'd2);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_late_busy", 64'(busy), 64'd0);

        mem[16'h0400] = 32'h7F7F_7F7F;
        rd_addrs.delete(); done_cnt = 0;
        base_addr = 16'h0400; num_words = 16'd1; play_en = 1'b1;
        repeat (50) tick();
        rst = 1'b1;
        tick();
        chk("rst_outs", 64'({pdm_out, ram_rd, busy, done, underrun}), 64'd0);
        num_words = 16'd0;
        rst = 1'b0;
        repeat (20) tick();
        chk("zero_words_rd", 64'(rd_addrs.size()), 64'd1);
        chk("zero_words_busy", 64'(busy), 64'd0);
        chk("zero_words_done", 64'(done_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
